// File: rtl/hd_pkg.sv
// Shared types, constants and the Hamming(7,4) encode function for the
// codeword-pair transmit path.
package hd_pkg;

  typedef logic [3:0] data_t;
  typedef logic [6:0] cw_t;

  localparam int unsigned P1 = 6;
  localparam int unsigned P2 = 5;
  localparam int unsigned P3 = 4;

  localparam logic [2:0] ERR_NONE = 3'd7;

  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  // Parity in cw[6:4], data word copied unchanged into cw[3:0].
  function automatic cw_t hamming74_enc(input data_t d);
    cw_t cw;
    cw        = '0;
    cw[3:0]   = d;
    cw[P1]    = d[3] ^ d[2] ^ d[1];
    cw[P2]    = d[3] ^ d[2] ^ d[0];
    cw[P3]    = d[3] ^ d[1] ^ d[0];
    return cw;
  endfunction

endpackage

// File: rtl/hd_pair_fifo.sv
// Synchronous FIFO for codeword pairs; head entry reads as zero when empty.
module hd_pair_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_push;
  logic         w_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hamming_pair_encoder.sv
// Hamming(7,4) encoder with optional single-bit error injection, packing
// consecutive codewords into (code_word1, code_word2) pairs behind a FIFO.
module hamming_pair_encoder
  import hd_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             in_err_en,
  input  logic [2:0]       in_err_pos,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       code_word1,
  output logic [6:0]       code_word2,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  state_t      r_state;
  state_t      w_state_nxt;
  cw_t         r_stage;
  cw_t         w_cw_enc;
  cw_t         w_cw;
  logic        w_flip;
  logic        w_accept;
  logic        w_take;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [13:0] w_head;
  logic [CNT_W-1:0] r_pair_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  assign w_cw_enc = hamming74_enc(in_data);
  assign w_flip   = in_err_en && (in_err_pos != ERR_NONE);
  assign w_cw     = w_cw_enc ^ (w_flip ? cw_t'(7'd1 << in_err_pos) : '0);

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready = (r_state == S_FIRST) || !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_take   = w_accept && !flush;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    if (flush) begin
      w_state_nxt = S_FIRST;
    end else if (w_accept) begin
      if (r_state == S_FIRST) begin
        w_state_nxt = S_SECOND;
      end else begin
        w_state_nxt = S_FIRST;
        w_push      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FIRST;
      r_stage    <= '0;
      r_pair_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush)
        r_stage <= '0;
      else if (w_take && (r_state == S_FIRST))
        r_stage <= w_cw;
      if (w_push)
        r_pair_cnt <= r_pair_cnt + 1'b1;
      if (w_take && w_flip)
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  hd_pair_fifo #(
    .DEPTH (DEPTH),
    .W     (14)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata ({r_stage, w_cw}),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign code_word1 = w_head[13:7];
  assign code_word2 = w_head[6:0];
  assign pair_cnt   = r_pair_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_hamming_pair_encoder.sv
// Scoreboard bench: driver pushes expected pairs, monitor pops on each
// downstream handshake and compares.
module tb_hamming_pair_encoder;
  import hd_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_data = '0;
  logic             in_err_en = 1'b0;
  logic [2:0]       in_err_pos = 3'd7;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [6:0]       code_word1;
  logic [6:0]       code_word2;
  logic [CNT_W-1:0] pair_cnt;
  logic [CNT_W-1:0] err_cnt;

  hamming_pair_encoder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_err_en  (in_err_en),
    .in_err_pos (in_err_pos),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .code_word1 (code_word1),
    .code_word2 (code_word2),
    .pair_cnt   (pair_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [13:0]      sb[$];
  bit               have_first = 0;
  logic [6:0]       first_cw = '0;
  logic [CNT_W-1:0] exp_pairs = '0;
  logic [CNT_W-1:0] exp_errs = '0;
  int               rdy_mode = 0;   // 0 hold low, 1 always high, 2 random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_cw(input logic [3:0] d, input logic een, input logic [2:0] pos);
    logic [6:0] cw;
    cw = hamming74_enc(d);
    if (een && pos <= 3'd6) cw[pos] = ~cw[pos];
    return cw;
  endfunction

  task automatic model_accept(input logic [3:0] d, input logic een, input logic [2:0] pos);
    logic [6:0] cw;
    cw = model_cw(d, een, pos);
    if (een && pos <= 3'd6) exp_errs++;
    if (!have_first) begin
      have_first = 1;
      first_cw   = cw;
    end else begin
      have_first = 0;
      sb.push_back({first_cw, cw});
      exp_pairs++;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    have_first = 0;
    first_cw   = '0;
    exp_pairs  = '0;
    exp_errs   = '0;
  endtask

  // Called and returns at a negedge.
  task automatic send(input logic [3:0] d, input logic een, input logic [2:0] pos);
    int unsigned waitc;
    waitc      = 0;
    in_valid   = 1'b1;
    in_data    = d;
    in_err_en  = een;
    in_err_pos = pos;
    while (!in_ready) begin
      @(negedge clk);
      waitc++;
      if (waitc > 300) begin
        chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    model_accept(d, een, pos);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_flush(input logic [3:0] d);
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_data    = d;
    in_err_en  = 1'b1;
    in_err_pos = 3'd2;
    @(posedge clk);
    have_first = 0;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int unsigned waitc;
    waitc    = 0;
    rdy_mode = 1;
    while (sb.size() != 0 || out_valid) begin
      @(negedge clk);
      waitc++;
      if (waitc > 500) begin
        chk("drain_timeout", sb.size(), 32'd0);
        return;
      end
    end
  endtask

  // out_ready changes just after the edge so it is stable for the monitor.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor
  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!out_valid) begin
          chk("empty_head_zero", {code_word1, code_word2}, 32'd0);
        end else if (out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_pair", {code_word1, code_word2}, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("pair", {code_word1, code_word2}, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] d;
    logic       een;
    logic [2:0] pos;

    repeat (3) @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_pair_cnt", pair_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // Basic pair, latency one edge
    rdy_mode = 0;
    send(4'b1011, 1'b0, 3'd7);
    chk("t1_no_valid_half", out_valid, 1'b0);
    send(4'b0110, 1'b0, 3'd7);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_cw1", code_word1, 7'h1B);
    chk("t1_cw2", code_word2, 7'h36);
    chk("t1_pair_cnt", pair_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);
    drain();

    // Injection at bit 6, pos 7 means no flip
    rdy_mode = 0;
    send(4'b1011, 1'b1, 3'd6);
    send(4'b0000, 1'b1, 3'd7);
    chk("t2_cw1", code_word1, 7'h5B);
    chk("t2_cw2", code_word2, 7'h00);
    chk("t2_err_cnt", err_cnt, 1);
    drain();

    // Full FIFO and backpressure
    rdy_mode = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) send(4'(i + 3), 1'b0, 3'd7);
    chk("t3_full_in_ready_first", in_ready, 1'b1);
    chk("t3_full_valid", out_valid, 1'b1);
    send(4'hC, 1'b0, 3'd7);
    chk("t3_full_in_ready_second", in_ready, 1'b0);
    rdy_mode = 1;
    @(negedge clk);
    chk("t3_pop_full_in_ready", out_ready && !in_ready, 1'b1);
    send(4'hD, 1'b0, 3'd7);
    drain();
    chk("t3_pair_cnt", pair_cnt, exp_pairs);

    // Flush with concurrent word
    rdy_mode = 0;
    @(negedge clk);
    send(4'hA, 1'b0, 3'd7);
    do_flush(4'h5);
    chk("t4_no_valid", out_valid, 1'b0);
    send(4'b0001, 1'b0, 3'd7);
    send(4'b1111, 1'b0, 3'd7);
    chk("t4_cw1", code_word1, 7'h31);
    chk("t4_cw2", code_word2, 7'h7F);
    chk("t4_err_cnt", err_cnt, exp_errs);
    drain();

    // Reset with 3 pairs queued, half pair staged
    rdy_mode = 0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) send(4'($urandom), 1'b1, 3'($urandom));
    chk("t5_pre_in_ready", in_ready, 1'b1);
    do_reset();
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_cw", {code_word1, code_word2}, 0);
    chk("t5_pair_cnt", pair_cnt, 0);
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_in_ready", in_ready, 1'b1);
    send(4'b1001, 1'b0, 3'd7);
    send(4'b0100, 1'b0, 3'd7);
    chk("t5_cw1", code_word1, model_cw(4'b1001, 1'b0, 3'd7));
    chk("t5_cw2", code_word2, model_cw(4'b0100, 1'b0, 3'd7));
    drain();

    // Random run, 256 pairs, counter wrap
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 512; i++) begin
      d   = 4'($urandom);
      een = 1'($urandom);
      pos = 3'($urandom);
      send(d, een, pos);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();
    chk("t6_pair_cnt_wrap", pair_cnt, 0);
    chk("t6_model_pairs", exp_pairs, 0);
    chk("t6_err_cnt", err_cnt, exp_errs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
